// File: rtl/onewire_master.sv
// Open-drain 1-Wire master: sequences reset/presence, write and read slots on an IOBUF pad.
// Build option: define ONEWIRE_SYNC_EN for a 2-flop pad_i synchronizer (default: single flop).
module onewire_master #(
  parameter int CLK_PER_US = 50,
  parameter int CW         = $clog2(960 * CLK_PER_US + 1)
) (
  input  logic       C,
  input  logic       CLR,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       rsp_err,
  output logic       busy,
  output logic       pad_o,
  output logic       pad_t,
  input  logic       pad_i
);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, RECOVER} state_t;

  localparam logic [CW-1:0] RST_LOW  = CW'(480 * CLK_PER_US - 1);
  localparam logic [CW-1:0] RST_SMP  = CW'(550 * CLK_PER_US - 1);
  localparam logic [CW-1:0] RST_SLOT = CW'(960 * CLK_PER_US - 1);
  localparam logic [CW-1:0] W0_LOW   = CW'(60 * CLK_PER_US - 1);
  localparam logic [CW-1:0] BIT_LOW  = CW'(6 * CLK_PER_US - 1);
  localparam logic [CW-1:0] BIT_SMP  = CW'(15 * CLK_PER_US - 1);
  localparam logic [CW-1:0] BIT_SLOT = CW'(70 * CLK_PER_US - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    cmd_q, cmd_q_n;
  logic          smp, smp_n;
  logic          err, err_n;
  logic          rsp_valid_n, rsp_bit_n, rsp_err_n, pad_t_n;
  logic          pad_s;
  logic [CW-1:0] low_m1, smp_m1, slot_m1;

`ifdef ONEWIRE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) sync <= '1;
    else     sync <= {sync[0], pad_i};
  end
  assign pad_s = sync[1];
`else
  logic sync;
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) sync <= 1'b1;
    else     sync <= pad_i;
  end
  assign pad_s = sync;
`endif

  always_comb begin
    low_m1  = BIT_LOW;
    smp_m1  = BIT_SMP;
    slot_m1 = BIT_SLOT;
    case (cmd_q)
      2'b00: begin
        low_m1  = RST_LOW;
        smp_m1  = RST_SMP;
        slot_m1 = RST_SLOT;
      end
      2'b01:   low_m1 = W0_LOW;
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_q_n     = cmd_q;
    smp_n       = smp;
    err_n       = err;
    rsp_valid_n = 1'b0;
    rsp_bit_n   = rsp_bit;
    rsp_err_n   = rsp_err;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cmd_q_n = cmd;
          cnt_n   = '0;
          smp_n   = 1'b0;
          err_n   = ~pad_s;
          state_n = pad_s ? DRIVE : RECOVER;
        end
      end
      DRIVE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == smp_m1) smp_n = pad_s;
        // Sample already taken inside the drive window: RELEASE would never see it, go straight to recovery.
        if (cnt == low_m1) state_n = (smp_m1 < low_m1) ? RECOVER : RELEASE;
      end
      RELEASE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == smp_m1) begin
          smp_n   = pad_s;
          state_n = RECOVER;
        end
      end
      RECOVER: begin
        if (cnt != slot_m1) cnt_n = cnt + 1'b1;
        if (err || cnt == slot_m1) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          rsp_err_n   = err;
          rsp_bit_n   = err ? 1'b0 : ((cmd_q == 2'b00) ? ~smp : smp);
        end
      end
      default: state_n = IDLE;
    endcase
    pad_t_n = (state_n != DRIVE);
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      smp       <= 1'b0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_bit   <= 1'b0;
      rsp_err   <= 1'b0;
      pad_t     <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_q     <= cmd_q_n;
      smp       <= smp_n;
      err       <= err_n;
      rsp_valid <= rsp_valid_n;
      rsp_bit   <= rsp_bit_n;
      rsp_err   <= rsp_err_n;
      pad_t     <= pad_t_n;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign pad_o     = 1'b0;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master at CLK_PER_US=4 with a wired-AND bus and simple device model.
module tb_onewire_master;

  logic       C = 1'b0;
  logic       CLR = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready, rsp_valid, rsp_bit, rsp_err, busy, pad_o, pad_t, pad_i;
  logic       dev_low = 1'b0;
  logic       stuck = 1'b0;
  int         checks = 0;
  int         passes = 0;

  onewire_master #(.CLK_PER_US(4)) dut (
    .C(C), .CLR(CLR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .rsp_err(rsp_err), .busy(busy),
    .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_i)
  );

  // Wired-AND line: master pulls low when pad_t=0, device pulls low via dev_low/stuck.
  assign pad_i = pad_t & ~dev_low & ~stuck;

  always #5 C = ~C;

  // Issues one command and measures the slot; cycle n=1 is the first cycle after the accept edge.
  task automatic run_slot(input logic [1:0] c, input int lo_s, input int lo_e,
                          output int low_cnt, output int rsp_cyc,
                          output logic bit_o, output logic err_o, output logic rdy_o);
    int n;
    n = 0; low_cnt = 0; rsp_cyc = 0; bit_o = 1'bx; err_o = 1'bx; rdy_o = 1'bx;
    cmd_valid = 1'b1;
    cmd = c;
    while (rsp_cyc == 0 && n < 5000) begin
      @(posedge C); #1;
      n++;
      cmd_valid = 1'b0;
      if (!pad_t) low_cnt++;
      if (rsp_valid) begin
        rsp_cyc = n;
        bit_o = rsp_bit;
        err_o = rsp_err;
        rdy_o = cmd_ready;
      end
      dev_low = (n >= lo_s && n < lo_e);
    end
    dev_low = 1'b0;
  endtask

  task automatic test_reset;
    CLR = 1'b1;
    repeat (3) @(posedge C);
    #1;
    checks++; if (pad_t !== 1'b1) $display("FAIL reset_pad_t got %b want 1", pad_t); else passes++;
    checks++; if (pad_o !== 1'b0) $display("FAIL reset_pad_o got %b want 0", pad_o); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_bit !== 1'b0) $display("FAIL reset_rsp_bit got %b want 0", rsp_bit); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", rsp_err); else passes++;
    @(negedge C);
    CLR = 1'b0;
    repeat (4) @(posedge C);
    #1;
  endtask

  task automatic test_presence;
    int lc, rc; logic b, e, r;
    run_slot(2'b00, 2000, 2480, lc, rc, b, e, r);
    checks++; if (lc !== 1920) $display("FAIL pres_low got %0d want 1920", lc); else passes++;
    checks++; if (rc !== 3841) $display("FAIL pres_rsp_cycle got %0d want 3841", rc); else passes++;
    checks++; if (b !== 1'b1) $display("FAIL pres_bit got %b want 1", b); else passes++;
    checks++; if (e !== 1'b0) $display("FAIL pres_err got %b want 0", e); else passes++;
    run_slot(2'b00, 0, 0, lc, rc, b, e, r);
    checks++; if (rc !== 3841) $display("FAIL nodev_rsp_cycle got %0d want 3841", rc); else passes++;
    checks++; if (b !== 1'b0) $display("FAIL nodev_bit got %b want 0", b); else passes++;
  endtask

  task automatic test_back_to_back;
    int lc, rc; logic b, e, r;
    run_slot(2'b10, 0, 0, lc, rc, b, e, r);
    checks++; if (lc !== 24) $display("FAIL w1_low got %0d want 24", lc); else passes++;
    checks++; if (rc !== 281) $display("FAIL w1_rsp_cycle got %0d want 281", rc); else passes++;
    checks++; if (b !== 1'b1) $display("FAIL w1_bit got %b want 1", b); else passes++;
    checks++; if (r !== 1'b1) $display("FAIL w1_ready_at_rsp got %b want 1", r); else passes++;
    run_slot(2'b01, 0, 0, lc, rc, b, e, r);
    checks++; if (lc !== 240) $display("FAIL w0_low got %0d want 240", lc); else passes++;
    checks++; if (rc !== 281) $display("FAIL w0_rsp_cycle got %0d want 281", rc); else passes++;
    checks++; if (b !== 1'b0) $display("FAIL w0_bit got %b want 0", b); else passes++;
    checks++; if (e !== 1'b0) $display("FAIL w0_err got %b want 0", e); else passes++;
  endtask

  task automatic test_read;
    int lc, rc; logic b, e, r;
    repeat (3) @(posedge C);
    #1;
    run_slot(2'b11, 24, 160, lc, rc, b, e, r);
    checks++; if (lc !== 24) $display("FAIL rd0_low got %0d want 24", lc); else passes++;
    checks++; if (b !== 1'b0) $display("FAIL rd0_bit got %b want 0", b); else passes++;
    run_slot(2'b11, 0, 0, lc, rc, b, e, r);
    checks++; if (rc !== 281) $display("FAIL rd1_rsp_cycle got %0d want 281", rc); else passes++;
    checks++; if (b !== 1'b1) $display("FAIL rd1_bit got %b want 1", b); else passes++;
  endtask

  task automatic test_stuck;
    int lc, rc; logic b, e, r;
    stuck = 1'b1;
    repeat (4) @(posedge C);
    #1;
    run_slot(2'b11, 0, 0, lc, rc, b, e, r);
    checks++; if (lc !== 0) $display("FAIL stuck_low got %0d want 0", lc); else passes++;
    checks++; if (rc !== 2) $display("FAIL stuck_rsp_cycle got %0d want 2", rc); else passes++;
    checks++; if (e !== 1'b1) $display("FAIL stuck_err got %b want 1", e); else passes++;
    checks++; if (b !== 1'b0) $display("FAIL stuck_bit got %b want 0", b); else passes++;
    @(posedge C); #1;
    checks++; if (rsp_err !== 1'b1) $display("FAIL stuck_err_held got %b want 1", rsp_err); else passes++;
    stuck = 1'b0;
    repeat (4) @(posedge C);
    #1;
  endtask

  task automatic test_clr;
    int n, rsps;
    n = 0; rsps = 0;
    cmd_valid = 1'b1;
    cmd = 2'b00;
    while (n < 1000) begin
      @(posedge C); #1;
      n++;
      cmd_valid = 1'b0;
    end
    checks++; if (pad_t !== 1'b0) $display("FAIL clr_pre_pad_t got %b want 0", pad_t); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL clr_pre_busy got %b want 1", busy); else passes++;
    CLR = 1'b1;
    #1;
    checks++; if (pad_t !== 1'b1) $display("FAIL clr_pad_t got %b want 1", pad_t); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL clr_cmd_ready got %b want 1", cmd_ready); else passes++;
    #2;
    CLR = 1'b0;
    repeat (4000) begin
      @(posedge C); #1;
      if (rsp_valid) rsps++;
    end
    checks++; if (rsps !== 0) $display("FAIL clr_no_rsp got %0d want 0", rsps); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL clr_ready_after got %b want 1", cmd_ready); else passes++;
  endtask

  initial begin
    test_reset();
    test_presence();
    test_back_to_back();
    test_read();
    test_stuck();
    test_clr();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
